// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake,
// and drives the IF/ID register with stall buffering and branch squash.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        Valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC & ~32'h3;
      hold_q     <= NOP_WORD;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // Redirect outranks everything, including a stalled or held fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (PCSrc) begin
      pc_d    = BranchTarget & ~32'h3;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      hold_d  = NOP_WORD;
      state_d = FETCH;
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (IMemReady && !Stall) begin
            instr_d    = IMemData;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
          end else if (IMemReady && Stall) begin
            hold_d  = IMemData;
            state_d = HELD;
          end else if (!IMemReady && !Stall) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        HELD: begin
          if (!Stall) begin
            instr_d    = hold_q;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
            state_d    = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign IMemReq     = (state_q == FETCH);
  assign IMemAddr    = pc_q;
  assign Instruction = instr_q;
  assign PCPlus4     = pc_plus4_q;
  assign Valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage using a combinational memory model
// whose data is the address XOR a key.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        Valid;

  logic [31:0] data_key;
  int          total_checks;
  int          passed_checks;
  int          failed_checks;

  instruction_fetch_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Stall        (Stall),
    .IMemReady    (IMemReady),
    .IMemData     (IMemData),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .Valid        (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign IMemData = IMemAddr ^ data_key;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic vld);
    check({tag, ".instr"}, Instruction, instr);
    check({tag, ".pcplus4"}, PCPlus4, pc4);
    check({tag, ".valid"}, {31'h0, Valid}, {31'h0, vld});
  endtask

  task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'h0, IMemReq}, {31'h0, req});
    check({tag, ".addr"}, IMemAddr, addr);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    data_key      = 32'hA5A5A5A5;
    Rst           = 1'b0;
    PCSrc         = 1'b0;
    BranchTarget  = 32'h0;
    Stall         = 1'b0;
    IMemReady     = 1'b1;

    // Reset values and BOOT
    #12;
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    check_mem("reset", 1'b0, 32'h0);
    Rst = 1'b1;
    #1;
    check_mem("boot", 1'b0, 32'h0);
    tick();
    check_mem("fetch0", 1'b1, 32'h0);
    check_ifid("fetch0", 32'h0, 32'h0, 1'b0);

    // Zero-wait stream
    tick();
    check_ifid("zw0", 32'hA5A5A5A5, 32'd4, 1'b1);
    tick();
    check_ifid("zw1", 32'hA5A5A5A1, 32'd8, 1'b1);
    tick();
    check_ifid("zw2", 32'hA5A5A5AD, 32'd12, 1'b1);
    check_mem("zw2", 1'b1, 32'd12);

    // Two wait states at PC=12
    IMemReady = 1'b0;
    tick();
    check_ifid("ws0", 32'h0, 32'd12, 1'b0);
    check_mem("ws0", 1'b1, 32'd12);
    tick();
    check_ifid("ws1", 32'h0, 32'd12, 1'b0);
    check_mem("ws1", 1'b1, 32'd12);
    IMemReady = 1'b1;
    tick();
    check_ifid("ws2", 32'hA5A5A5A9, 32'd16, 1'b1);
    check_mem("ws2", 1'b1, 32'd16);

    // Restart from reset, then stall at PC=8
    #2;
    Rst = 1'b0;
    #1;
    Rst = 1'b1;
    tick();
    tick();
    tick();
    check_ifid("pre_stall", 32'hA5A5A5A1, 32'd8, 1'b1);
    Stall = 1'b1;
    tick();
    check_ifid("held0", 32'hA5A5A5A1, 32'd8, 1'b1);
    check_mem("held0", 1'b0, 32'd8);
    data_key = 32'h0;
    tick();
    check_ifid("held1", 32'hA5A5A5A1, 32'd8, 1'b1);
    tick();
    check_ifid("held2", 32'hA5A5A5A1, 32'd8, 1'b1);
    check_mem("held2", 1'b0, 32'd8);
    Stall    = 1'b0;
    data_key = 32'hA5A5A5A5;
    tick();
    check_ifid("release", 32'hA5A5A5AD, 32'd12, 1'b1);
    check_mem("release", 1'b1, 32'd12);

    // Redirect while held and stalled squashes the hold word
    Stall = 1'b1;
    tick();
    check_mem("held_b", 1'b0, 32'd12);
    PCSrc        = 1'b1;
    BranchTarget = 32'h00000103;
    tick();
    check_ifid("redir", 32'h0, 32'd12, 1'b0);
    check_mem("redir", 1'b1, 32'h00000100);
    PCSrc = 1'b0;
    Stall = 1'b0;
    tick();
    check_ifid("target", 32'hA5A5A4A5, 32'h00000104, 1'b1);

    // PC wrap at the top of the address space
    PCSrc        = 1'b1;
    BranchTarget = 32'hFFFFFFFF;
    tick();
    check_mem("wrap_pre", 1'b1, 32'hFFFFFFFC);
    PCSrc = 1'b0;
    tick();
    check_ifid("wrap", 32'h5A5A5A59, 32'h0, 1'b1);
    check_mem("wrap", 1'b1, 32'h0);
    tick();
    check_ifid("after_wrap", 32'hA5A5A5A5, 32'd4, 1'b1);

    // Asynchronous reset in the middle of a wait at PC=0x40
    PCSrc        = 1'b1;
    BranchTarget = 32'h00000040;
    tick();
    PCSrc     = 1'b0;
    IMemReady = 1'b0;
    tick();
    check_ifid("wait40", 32'h0, 32'd4, 1'b0);
    check_mem("wait40", 1'b1, 32'h40);
    #2;
    Rst = 1'b0;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 1'b0);
    check_mem("async_rst", 1'b0, 32'h0);
    #2;
    Rst       = 1'b1;
    IMemReady = 1'b1;
    tick();
    check_mem("refetch", 1'b1, 32'h0);
    tick();
    check_ifid("refetch", 32'hA5A5A5A5, 32'd4, 1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
